// File: rtl/c6_operand_loader_pkg.sv
// Shared definitions for the C6 operand loader: FSM encoding and default geometry.
package c6_operand_loader_pkg;

  localparam int C6_WIDTH       = 8;
  localparam int C6_SYNC_STAGES = 2;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_ISSUE   = 1'b1
  } c6_state_e;

endpackage

// File: rtl/c6_operand_loader_if.sv
// Operand-pair handshake toward the C6 multiplier core.
interface c6_operand_loader_if
  import c6_operand_loader_pkg::*;
#(
  parameter int WIDTH = C6_WIDTH
);

  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_b;

  modport master (output m_valid, output m_a, output m_b, input m_ready);
  modport slave  (input m_valid, input m_a, input m_b, output m_ready);

endinterface

// File: rtl/c6_operand_loader_sync_edge.sv
// Pin synchroniser followed by a rising-edge detector producing a one-cycle event pulse.
module c6_operand_loader_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   hist_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p <= '0;
      hist_p <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], pin};
      hist_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_p[SYNC_STAGES-1] & ~hist_p;

endmodule

// File: rtl/c6_operand_loader.sv
// Captures A/B operands from the shared bus under strobe events and issues them on valid/ready.
module c6_operand_loader
  import c6_operand_loader_pkg::*;
#(
  parameter int WIDTH       = C6_WIDTH,
  parameter int SYNC_STAGES = C6_SYNC_STAGES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       ld_a_in,
  input  logic                       ld_b_in,
  input  logic                       go_in,
  input  logic                       clr_in,
  c6_operand_loader_if.master        m_if,
  output logic                       a_loaded,
  output logic                       b_loaded,
  output logic                       busy,
  output logic                       err_miss,
  output logic                       err_ovr
);

  logic [3:0] pins;
  logic [3:0] ev;
  logic       lda_ev, ldb_ev, go_ev, clr_ev;

  assign pins = {clr_in, go_in, ld_b_in, ld_a_in};

  for (genvar i = 0; i < 4; i++) begin : g_sync
    c6_operand_loader_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst   (rst),
      .pin   (pins[i]),
      .pulse (ev[i])
    );
  end

  assign {clr_ev, go_ev, ldb_ev, lda_ev} = ev;

  c6_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             al_q, al_d, bl_q, bl_d;
  logic             miss_q, miss_d, ovr_q, ovr_d;

  // Next-state: clr overrides everything; go sees the flags after same-cycle loads.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    al_d    = al_q;
    bl_d    = bl_q;
    miss_d  = miss_q;
    ovr_d   = ovr_q;
    if (clr_ev) begin
      state_d = ST_COLLECT;
      a_d     = '0;
      b_d     = '0;
      al_d    = 1'b0;
      bl_d    = 1'b0;
      miss_d  = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_COLLECT: begin
          if (lda_ev) begin
            a_d  = data_in;
            al_d = 1'b1;
          end
          if (ldb_ev) begin
            b_d  = data_in;
            bl_d = 1'b1;
          end
          if (go_ev) begin
            if (al_d && bl_d) state_d = ST_ISSUE;
            else              miss_d  = 1'b1;
          end
        end
        ST_ISSUE: begin
          if (lda_ev || ldb_ev) ovr_d = 1'b1;
          if (m_if.m_ready) begin
            state_d = ST_COLLECT;
            al_d    = 1'b0;
            bl_d    = 1'b0;
          end
        end
        default: state_d = ST_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      a_q     <= '0;
      b_q     <= '0;
      al_q    <= 1'b0;
      bl_q    <= 1'b0;
      miss_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      al_q    <= al_d;
      bl_q    <= bl_d;
      miss_q  <= miss_d;
      ovr_q   <= ovr_d;
    end
  end

  assign m_if.m_valid = (state_q == ST_ISSUE);
  assign m_if.m_a     = a_q;
  assign m_if.m_b     = b_q;
  assign busy         = (state_q == ST_ISSUE);
  assign a_loaded     = al_q;
  assign b_loaded     = bl_q;
  assign err_miss     = miss_q;
  assign err_ovr      = ovr_q;

endmodule

// File: tb/tb_c6_operand_loader.sv
// Randomised strobe-level bench for c6_operand_loader against a transaction-level reference model.
module tb_c6_operand_loader;

  localparam int W    = 8;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         ld_a_in, ld_b_in, go_in, clr_in;
  logic         a_loaded, b_loaded, busy, err_miss, err_ovr;

  c6_operand_loader_if #(.WIDTH(W)) bus ();

  c6_operand_loader #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .ld_a_in  (ld_a_in),
    .ld_b_in  (ld_b_in),
    .go_in    (go_in),
    .clr_in   (clr_in),
    .m_if     (bus.master),
    .a_loaded (a_loaded),
    .b_loaded (b_loaded),
    .busy     (busy),
    .err_miss (err_miss),
    .err_ovr  (err_ovr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: operand state and expected transfers at transaction level
  logic [W-1:0] mdl_a, mdl_b;
  bit           mdl_al, mdl_bl, mdl_miss, mdl_ovr, mdl_issue, mdl_ready;
  logic [15:0]  exp_q[$];
  logic [15:0]  obs_q[$];

  always @(posedge clk)
    if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) obs_q.push_back({bus.m_a, bus.m_b});

  task automatic m_reset();
    mdl_a = '0; mdl_b = '0; mdl_al = 0; mdl_bl = 0;
    mdl_miss = 0; mdl_ovr = 0; mdl_issue = 0;
  endtask

  task automatic m_try_xfer();
    if (mdl_issue && mdl_ready) begin
      exp_q.push_back({mdl_a, mdl_b});
      mdl_issue = 0; mdl_al = 0; mdl_bl = 0;
    end
  endtask

  task automatic m_ld(input bit is_b, input logic [W-1:0] d);
    if (mdl_issue) mdl_ovr = 1;
    else if (is_b) begin mdl_b = d; mdl_bl = 1; end
    else begin mdl_a = d; mdl_al = 1; end
  endtask

  task automatic m_go();
    if (!mdl_issue) begin
      if (mdl_al && mdl_bl) begin mdl_issue = 1; m_try_xfer(); end
      else mdl_miss = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, bus.m_valid, mdl_issue);
    chk({tag, ".busy"},  busy,        mdl_issue);
    chk({tag, ".m_a"},   bus.m_a,     mdl_a);
    chk({tag, ".m_b"},   bus.m_b,     mdl_b);
    chk({tag, ".al"},    a_loaded,    mdl_al);
    chk({tag, ".bl"},    b_loaded,    mdl_bl);
    chk({tag, ".miss"},  err_miss,    mdl_miss);
    chk({tag, ".ovr"},   err_ovr,     mdl_ovr);
    chk({tag, ".nxfer"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk({tag, ".xfer"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  // op: 0=ld_a 1=ld_b 2=go 3=clr
  task automatic strobe(input int op, input logic [W-1:0] d);
    @(negedge clk);
    data_in = d;
    case (op)
      0: ld_a_in = 1'b1;
      1: ld_b_in = 1'b1;
      2: go_in   = 1'b1;
      default: clr_in = 1'b1;
    endcase
    repeat (SYNC + 3) @(negedge clk);
    ld_a_in = 1'b0; ld_b_in = 1'b0; go_in = 1'b0; clr_in = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
    case (op)
      0: m_ld(0, d);
      1: m_ld(1, d);
      2: m_go();
      default: m_reset();
    endcase
  endtask

  task automatic set_ready(input bit r);
    @(negedge clk);
    bus.m_ready = r;
    mdl_ready   = r;
    repeat (3) @(negedge clk);
    m_try_xfer();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; data_in = '0; ld_a_in = 0; ld_b_in = 0; go_in = 0; clr_in = 0;
    bus.m_ready = 1'b0; mdl_ready = 0;
    m_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Load and issue with ready already high
    set_ready(1);
    strobe(0, 8'h0D); strobe(1, 8'h0B);
    check_all("ld_ab");
    strobe(2, 8'h00);
    check_all("issue");

    // Missing operand
    set_ready(0);
    strobe(3, 8'h00);
    strobe(0, 8'h05); strobe(2, 8'h00);
    check_all("miss");

    // Backpressure with a load while busy
    strobe(3, 8'h00);
    strobe(0, 8'h21); strobe(1, 8'h43); strobe(2, 8'h00);
    check_all("bp_issue");
    strobe(0, 8'hFF);
    check_all("bp_ovr");
    set_ready(1);
    check_all("bp_xfer");

    // Simultaneous strobes: both flags rise together SYNC+1 edges after the pin
    set_ready(0);
    strobe(3, 8'h00);
    @(negedge clk);
    data_in = 8'h3C; ld_a_in = 1'b1; ld_b_in = 1'b1;
    for (int e = 1; e <= SYNC + 1; e++) begin
      @(negedge clk);
      if (e < SYNC + 1) chk("sim_early", {a_loaded, b_loaded}, 2'b00);
      else              chk("sim_rise",  {a_loaded, b_loaded}, 2'b11);
    end
    repeat (SYNC + 2) @(negedge clk);
    ld_a_in = 1'b0; ld_b_in = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
    m_ld(0, 8'h3C); m_ld(1, 8'h3C);
    check_all("sim");

    // Clear event while issuing, coinciding with m_ready rising
    strobe(2, 8'h00);
    strobe(1, 8'h99);
    check_all("clr_pre");
    @(negedge clk);
    clr_in = 1'b1;
    repeat (SYNC) @(negedge clk);
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("clr_valid", bus.m_valid, 1'b0);
    chk("clr_m_a",   bus.m_a,     8'h00);
    chk("clr_ovr",   err_ovr,     1'b0);
    repeat (SYNC + 2) @(negedge clk);
    clr_in = 1'b0;
    bus.m_ready = 1'b0; mdl_ready = 0;
    repeat (SYNC + 3) @(negedge clk);
    obs_q.delete();
    m_reset();
    check_all("clr");

    // Async reset mid-issue
    strobe(0, 8'h12); strobe(1, 8'h34); strobe(2, 8'h00);
    check_all("rst_pre");
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", bus.m_valid, 1'b0);
    chk("arst_m_a",   bus.m_a,     8'h00);
    chk("arst_busy",  busy,        1'b0);
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all("arst");

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3)      strobe(0, W'($urandom));
      else if (r < 6) strobe(1, W'($urandom));
      else if (r < 8) strobe(2, W'($urandom));
      else if (r < 9) set_ready(!mdl_ready);
      else            strobe(3, W'($urandom));
      check_all("rand");
    end

    // Strobe held through reset gives exactly one load
    @(negedge clk);
    rst = 1'b1; bus.m_ready = 1'b0; mdl_ready = 0;
    data_in = 8'h77; ld_a_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (SYNC + 4) @(negedge clk);
    data_in = 8'h55;
    repeat (4) @(negedge clk);
    ld_a_in = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
    m_reset();
    m_ld(0, 8'h77);
    check_all("rst_hold");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
